// File: rtl/asg_frame_scheduler.sv
// Double-buffered pattern scheduler: streams words into a back frame and commits it to DATA on radar trigger.
// Commit/TRIG/EN one cycle after trigger; S_READY low while the back frame is full (or in reset).
module asg_frame_scheduler #(
    parameter int SIZE   = 3200,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              SYS_CLK,
    input  logic              RESETN,
    input  logic              RADAR_TRIG_PE,
    input  logic              ARM,
    input  logic              FLUSH,
    input  logic [WORD_W-1:0] S_DATA,
    input  logic              S_VALID,
    output logic              S_READY,
    output logic [SIZE-1:0]   DATA,
    output logic              EN,
    output logic              TRIG,
    output logic              BACK_FULL,
    output logic [CNT_W-1:0]  FRAME_CNT,
    output logic [CNT_W-1:0]  UNDERRUN_CNT
);

    localparam int NW   = SIZE / WORD_W;
    localparam int WP_W = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {ST_FILL, ST_FULL} state_t;

    state_t            r_state, w_state_nxt;
    logic [WP_W-1:0]   r_wp, w_wp_nxt;
    logic [SIZE-1:0]   r_back;
    logic [SIZE-1:0]   r_data;
    logic              r_s_ready;
    logic              r_valid_frame, w_valid_nxt;
    logic              r_en, r_trig;
    logic [CNT_W-1:0]  r_frame_cnt, r_underrun_cnt;
    logic              w_xfer, w_last, w_commit, w_underrun;

    // Trigger decisions use the state before this cycle's transfer.
    assign w_xfer      = S_VALID & r_s_ready & ~FLUSH;
    assign w_last      = w_xfer && (r_wp == WP_W'(NW - 1));
    assign w_commit    = RADAR_TRIG_PE && (r_state == ST_FULL);
    assign w_underrun  = RADAR_TRIG_PE && (r_state == ST_FILL);
    assign w_valid_nxt = r_valid_frame | w_commit;

    always_comb begin
        w_state_nxt = r_state;
        w_wp_nxt    = r_wp;
        if (w_commit) begin
            w_state_nxt = ST_FILL;
            w_wp_nxt    = '0;
        end else if (w_xfer) begin
            if (w_last) begin
                w_state_nxt = ST_FULL;
                w_wp_nxt    = '0;
            end else begin
                w_wp_nxt = r_wp + 1'b1;
            end
        end
        if (FLUSH) begin
            w_state_nxt = ST_FILL;
            w_wp_nxt    = '0;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state   <= ST_FILL;
            r_wp      <= '0;
            r_s_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wp      <= w_wp_nxt;
            r_s_ready <= (w_state_nxt == ST_FILL);
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_back         <= '0;
            r_data         <= '0;
            r_valid_frame  <= 1'b0;
            r_en           <= 1'b0;
            r_trig         <= 1'b0;
            r_frame_cnt    <= '0;
            r_underrun_cnt <= '0;
        end else begin
            r_trig        <= RADAR_TRIG_PE;
            r_valid_frame <= w_valid_nxt;
            r_en          <= ARM & w_valid_nxt;
            if (w_xfer)
                r_back[r_wp*WORD_W +: WORD_W] <= S_DATA;
            if (w_commit) begin
                r_data      <= r_back;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_underrun && (r_underrun_cnt != '1))
                r_underrun_cnt <= r_underrun_cnt + 1'b1;
        end
    end

    assign S_READY      = r_s_ready;
    assign DATA         = r_data;
    assign EN           = r_en;
    assign TRIG         = r_trig;
    assign BACK_FULL    = (r_state == ST_FULL);
    assign FRAME_CNT    = r_frame_cnt;
    assign UNDERRUN_CNT = r_underrun_cnt;

endmodule

// File: tb/tb_asg_frame_scheduler.sv
// Directed bench for asg_frame_scheduler: load/commit, underrun, coincident last word, flush, ARM gating, mid-fill reset.
module tb_asg_frame_scheduler;

    localparam int SIZE   = 3200;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;
    localparam int NW     = SIZE / WORD_W;

    logic              SYS_CLK = 1'b0;
    logic              RESETN;
    logic              RADAR_TRIG_PE;
    logic              ARM;
    logic              FLUSH;
    logic [WORD_W-1:0] S_DATA;
    logic              S_VALID;
    logic              S_READY;
    logic [SIZE-1:0]   DATA;
    logic              EN;
    logic              TRIG;
    logic              BACK_FULL;
    logic [CNT_W-1:0]  FRAME_CNT;
    logic [CNT_W-1:0]  UNDERRUN_CNT;

    int vectors     = 0;
    int miscompares = 0;

    asg_frame_scheduler #(.SIZE(SIZE), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .SYS_CLK      (SYS_CLK),
        .RESETN       (RESETN),
        .RADAR_TRIG_PE(RADAR_TRIG_PE),
        .ARM          (ARM),
        .FLUSH        (FLUSH),
        .S_DATA       (S_DATA),
        .S_VALID      (S_VALID),
        .S_READY      (S_READY),
        .DATA         (DATA),
        .EN           (EN),
        .TRIG         (TRIG),
        .BACK_FULL    (BACK_FULL),
        .FRAME_CNT    (FRAME_CNT),
        .UNDERRUN_CNT (UNDERRUN_CNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic push(input logic [WORD_W-1:0] w);
        S_VALID = 1'b1;
        S_DATA  = w;
        tick();
        S_VALID = 1'b0;
    endtask

    task automatic push_range(input int base, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) push(WORD_W'(base + i));
    endtask

    task automatic trig();
        RADAR_TRIG_PE = 1'b1;
        tick();
        RADAR_TRIG_PE = 1'b0;
    endtask

    function automatic logic [WORD_W-1:0] slot(input int k);
        return DATA[k*WORD_W +: WORD_W];
    endfunction

    initial begin
        RESETN = 1'b0; RADAR_TRIG_PE = 1'b0; ARM = 1'b1; FLUSH = 1'b0;
        S_DATA = '0; S_VALID = 1'b0;
        #12;
        chk("rst_s_ready", S_READY, 0);
        chk("rst_data_lo", slot(0), 0);
        chk("rst_en", EN, 0);
        chk("rst_trig", TRIG, 0);
        chk("rst_back_full", BACK_FULL, 0);
        chk("rst_frame_cnt", FRAME_CNT, 0);
        chk("rst_underrun_cnt", UNDERRUN_CNT, 0);
        tick();
        RESETN = 1'b1;
        tick(); tick();
        chk("post_rst_s_ready", S_READY, 1);

        // Trigger with nothing loaded
        trig();
        chk("empty_trig_pulse", TRIG, 1);
        chk("empty_underrun", UNDERRUN_CNT, 1);
        chk("empty_data", slot(0), 0);
        chk("empty_en", EN, 0);
        tick();
        chk("empty_trig_drop", TRIG, 0);

        // Partial load of 40 words, then three underrun triggers
        push_range(0, 0, 39);
        trig(); trig(); trig();
        chk("partial_underrun", UNDERRUN_CNT, 4);
        chk("partial_data", slot(0), 0);
        chk("partial_back_full", BACK_FULL, 0);
        chk("partial_s_ready", S_READY, 1);
        push_range(0, 40, 98);
        chk("pre_last_s_ready", S_READY, 1);
        push(WORD_W'(99));
        chk("full_s_ready", S_READY, 0);
        chk("full_back_full", BACK_FULL, 1);
        trig();
        chk("commit1_lo", slot(0), 0);
        chk("commit1_mid", slot(40), 40);
        chk("commit1_hi", DATA[3199:3168], 99);
        chk("commit1_trig", TRIG, 1);
        chk("commit1_frame_cnt", FRAME_CNT, 1);
        chk("commit1_en", EN, 1);
        chk("commit1_back_full", BACK_FULL, 0);
        chk("commit1_s_ready", S_READY, 1);
        tick();
        chk("commit1_trig_drop", TRIG, 0);

        // Trigger coincides with the last word
        push_range('h200, 0, 98);
        S_VALID = 1'b1; S_DATA = WORD_W'('h200 + 99); RADAR_TRIG_PE = 1'b1;
        tick();
        S_VALID = 1'b0; RADAR_TRIG_PE = 1'b0;
        chk("coinc_underrun", UNDERRUN_CNT, 5);
        chk("coinc_back_full", BACK_FULL, 1);
        chk("coinc_data_kept", DATA[3199:3168], 99);
        chk("coinc_frame_cnt", FRAME_CNT, 1);
        trig();
        chk("coinc_commit_lo", slot(0), 'h200);
        chk("coinc_commit_hi", DATA[3199:3168], 'h200 + 99);
        chk("coinc_frame_cnt2", FRAME_CNT, 2);

        // Flush a full frame, then trigger: old frame repeats
        push_range('h300, 0, 99);
        chk("b_back_full", BACK_FULL, 1);
        FLUSH = 1'b1; S_VALID = 1'b1; S_DATA = 32'hDEAD;
        tick();
        FLUSH = 1'b0; S_VALID = 1'b0;
        chk("flush_back_full", BACK_FULL, 0);
        chk("flush_s_ready", S_READY, 1);
        trig();
        chk("flush_data_kept", slot(0), 'h200);
        chk("flush_underrun", UNDERRUN_CNT, 6);
        push_range('h400, 0, 99);
        trig();
        chk("c_commit_lo", slot(0), 'h400);
        chk("c_commit_hi", DATA[3199:3168], 'h400 + 99);
        chk("c_frame_cnt", FRAME_CNT, 3);

        // Flush and trigger together on a full frame: commit wins
        push_range('h500, 0, 99);
        FLUSH = 1'b1; RADAR_TRIG_PE = 1'b1;
        tick();
        FLUSH = 1'b0; RADAR_TRIG_PE = 1'b0;
        chk("flushtrig_commit", slot(0), 'h500);
        chk("flushtrig_frame_cnt", FRAME_CNT, 4);
        chk("flushtrig_back_full", BACK_FULL, 0);

        // ARM gates EN only
        push_range('h600, 0, 99);
        ARM = 1'b0;
        trig();
        chk("disarm_en", EN, 0);
        chk("disarm_frame_cnt", FRAME_CNT, 5);
        chk("disarm_commit", slot(0), 'h600);
        ARM = 1'b1;
        tick(); tick();
        chk("rearm_en", EN, 1);

        // Asynchronous reset mid-fill
        push_range('h700, 0, 56);
        chk("midfill_en", EN, 1);
        RESETN = 1'b0;
        #1;
        chk("arst_en", EN, 0);
        chk("arst_data", slot(0), 0);
        chk("arst_frame_cnt", FRAME_CNT, 0);
        chk("arst_underrun", UNDERRUN_CNT, 0);
        chk("arst_back_full", BACK_FULL, 0);
        tick();
        RESETN = 1'b1;
        tick(); tick();
        chk("arst_s_ready", S_READY, 1);
        push(32'hABC);
        push_range('h800, 1, 99);
        chk("arst_refill_full", BACK_FULL, 1);
        trig();
        chk("arst_slot0", slot(0), 'hABC);
        chk("arst_slot1", slot(1), 'h801);
        chk("arst_frame_cnt2", FRAME_CNT, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
